// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the two-master RAM port arbiter.
package ram_port_arbiter_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int WE_WIDTH   = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

  // A disabled watchdog still needs a one-bit timer so the declarations stay legal.
  function automatic int timer_width(input int timeout_cycles);
    if (timeout_cycles > 0) begin
      return $clog2(timeout_cycles + 1);
    end
    return 1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// stb/ack/err bus between a requester (master) and a responder (slave).
interface ram_port_arbiter_if;
  import ram_port_arbiter_pkg::*;

  logic                  stb;
  logic [WE_WIDTH-1:0]   we;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ack;
  logic                  err;

  modport master (output stb, we, addr, wdata, input rdata, ack, err);
  modport slave  (input stb, we, addr, wdata, output rdata, ack, err);

endinterface

// File: rtl/ram_port_arbiter_rr_grant2.sv
// Two-input round-robin grant: a lone requester wins, a tie goes to the master not granted last.
module rr_grant2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt,
  output logic       any
);

  always_comb begin
    any = |req;
    gnt = 1'b0;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_grant;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter for two masters sharing one RAM port, one outstanding
// transaction at a time, with a watchdog that retires a missing ack as err.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  ram_port_arbiter_if.slave  m0,
  ram_port_arbiter_if.slave  m1,
  ram_port_arbiter_if.master s
);

  localparam int                 TIMER_W     = timer_width(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_SAT   = '1;
  localparam logic [TIMER_W-1:0] TIMER_LAST  = (TIMEOUT_CYCLES > 0) ? TIMER_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit                 WATCHDOG_EN = (TIMEOUT_CYCLES > 0);

  arb_state_t            state_reg, state_next;
  logic                  owner_reg, owner_next;
  logic                  last_grant_reg, last_grant_next;
  logic [TIMER_W-1:0]    timer_reg, timer_next;
  logic                  gnt, any_req;
  logic                  s_stb_raw;
  logic                  in_wait, resp, timeout_hit;
  logic [1:0]            m_ack, m_err;
  logic [DATA_WIDTH-1:0] m_rdata [2];

  rr_grant2 u_rr_grant2 (
    .req        ({m1.stb, m0.stb}),
    .last_grant (last_grant_reg),
    .gnt        (gnt),
    .any        (any_req)
  );

  assign in_wait     = (state_reg == ARB_WAIT);
  assign resp        = s.ack | s.err;
  assign timeout_hit = WATCHDOG_EN && in_wait && !resp && (timer_reg == TIMER_LAST);

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    timer_next      = timer_reg;
    s_stb_raw       = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        if (any_req) begin
          s_stb_raw       = 1'b1;
          owner_next      = gnt;
          last_grant_next = gnt;
          timer_next      = '0;
          state_next      = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (resp || timeout_hit) begin
          state_next = ARB_IDLE;
        end else if (timer_reg != TIMER_SAT) begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg      <= ARB_IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      timer_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      timer_reg      <= timer_next;
    end
  end

  // IDLE decodes stb combinationally, so the strobe is masked while reset is held.
  assign s.stb   = s_stb_raw & rstn_i;
  assign s.we    = gnt ? m1.we    : m0.we;
  assign s.addr  = gnt ? m1.addr  : m0.addr;
  assign s.wdata = gnt ? m1.wdata : m0.wdata;

  for (genvar gi = 0; gi < 2; gi++) begin : g_route
    logic is_owner;
    assign is_owner     = (owner_reg == 1'(gi));
    assign m_ack[gi]    = in_wait && is_owner && s.ack;
    assign m_err[gi]    = in_wait && is_owner && (s.err || timeout_hit);
    assign m_rdata[gi]  = is_owner ? s.rdata : '0;
  end

  assign m0.ack   = m_ack[0];
  assign m0.err   = m_err[0];
  assign m0.rdata = m_rdata[0];
  assign m1.ack   = m_ack[1];
  assign m1.err   = m_err[1];
  assign m1.rdata = m_rdata[1];

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Arbiter plus a behavioural RAM stub; a transaction-level model checks every cycle.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  localparam int TIMEOUT   = 16;
  localparam int MEM_WORDS = 4096;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if m0_bus ();
  ram_port_arbiter_if m1_bus ();
  ram_port_arbiter_if s_bus ();

  ram_port_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .m0     (m0_bus),
    .m1     (m1_bus),
    .s      (s_bus)
  );

  // master drive
  logic        mst_stb   [2];
  logic [3:0]  mst_we    [2];
  logic [31:0] mst_addr  [2];
  logic [31:0] mst_wdata [2];
  assign m0_bus.stb = mst_stb[0];  assign m0_bus.we = mst_we[0];
  assign m0_bus.addr = mst_addr[0]; assign m0_bus.wdata = mst_wdata[0];
  assign m1_bus.stb = mst_stb[1];  assign m1_bus.we = mst_we[1];
  assign m1_bus.addr = mst_addr[1]; assign m1_bus.wdata = mst_wdata[1];

  // RAM stub: acks one cycle after s_stb unless muted
  logic [31:0] ram [MEM_WORDS];
  logic        ram_mute = 1'b0;
  logic        ram_both = 1'b0;
  logic        ram_ack_q = 1'b0;
  logic [31:0] ram_rdata_q = '0;
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  always @(posedge clk) begin
    ram_ack_q <= s_bus.stb && !ram_mute;
    if (pl_en) ram[pl_addr] <= pl_data;
    if (s_bus.stb) begin
      ram_rdata_q <= ram[s_bus.addr[13:2]];
      for (int b = 0; b < 4; b++)
        if (s_bus.we[b]) ram[s_bus.addr[13:2]][8*b +: 8] <= s_bus.wdata[8*b +: 8];
    end
  end
  assign s_bus.ack   = ram_ack_q;
  assign s_bus.err   = ram_ack_q && ram_both;
  assign s_bus.rdata = ram_rdata_q;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state
  logic [31:0] shadow [MEM_WORDS];
  bit          mdl_busy, mdl_owner, mdl_last, mdl_read;
  int          mdl_age;
  logic [31:0] mdl_exp_rdata;

  // monitor / master bookkeeping
  bit          mon_ack [2], mon_err [2];
  logic [31:0] mon_rdata [2];
  int          sstb_cyc;
  bit          req_pend [2];
  int          start_cyc [2], res_cyc [2];
  bit          res_ack [2], res_err [2];
  logic [31:0] res_rdata [2];
  int          done_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    logic [1:0] req;
    bit         win, e_stb;
    bit [1:0]   e_ack, e_err;
    int         idx;
    mon_ack[0] = m0_bus.ack; mon_err[0] = m0_bus.err; mon_rdata[0] = m0_bus.rdata;
    mon_ack[1] = m1_bus.ack; mon_err[1] = m1_bus.err; mon_rdata[1] = m1_bus.rdata;
    if (s_bus.stb === 1'b1) sstb_cyc = cyc;
    if (pl_en) shadow[pl_addr] = pl_data;
    e_stb = 0; e_ack = '0; e_err = '0; win = 0;
    if (!rstn) begin
      mdl_busy = 0; mdl_owner = 0; mdl_last = 1; mdl_age = 0;
    end else if (!mdl_busy) begin
      req = {mst_stb[1], mst_stb[0]};
      if (req != 2'b00) begin
        e_stb = 1;
        win = (req == 2'b11) ? !mdl_last : req[1];
      end
    end else begin
      if (s_bus.ack || s_bus.err) begin
        e_ack[mdl_owner] = s_bus.ack;
        e_err[mdl_owner] = s_bus.err;
      end else if (mdl_age == TIMEOUT - 1) begin
        e_err[mdl_owner] = 1;
      end
    end
    check("s_stb", 32'(s_bus.stb), 32'(e_stb));
    if (e_stb) begin
      check("s_we", 32'(s_bus.we), 32'(mst_we[win]));
      check("s_addr", s_bus.addr, mst_addr[win]);
      check("s_wdata", s_bus.wdata, mst_wdata[win]);
    end
    check("m0_ack", 32'(mon_ack[0]), 32'(e_ack[0]));
    check("m1_ack", 32'(mon_ack[1]), 32'(e_ack[1]));
    check("m0_err", 32'(mon_err[0]), 32'(e_err[0]));
    check("m1_err", 32'(mon_err[1]), 32'(e_err[1]));
    if (rstn && mdl_busy) begin
      if (e_ack[mdl_owner] && mdl_read) check("owner_rdata", mon_rdata[mdl_owner], mdl_exp_rdata);
      check("nonowner_rdata", mon_rdata[!mdl_owner], 32'h0);
    end
    if (rstn) begin
      if (e_stb) begin
        mdl_busy = 1; mdl_owner = win; mdl_last = win; mdl_age = 0;
        idx = int'(mst_addr[win][13:2]);
        mdl_read = (mst_we[win] == 4'h0);
        mdl_exp_rdata = shadow[idx];
        for (int b = 0; b < 4; b++)
          if (mst_we[win][b]) shadow[idx][8*b +: 8] = mst_wdata[win][8*b +: 8];
      end else if (mdl_busy) begin
        if (s_bus.ack || s_bus.err || mdl_age == TIMEOUT - 1) mdl_busy = 0;
        else mdl_age++;
      end
    end
  endtask

  task automatic advance_phase();
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (req_pend[i] && (mon_ack[i] || mon_err[i])) begin
        req_pend[i] = 0; mst_stb[i] = 0;
        res_ack[i] = mon_ack[i]; res_err[i] = mon_err[i];
        res_rdata[i] = mon_rdata[i]; res_cyc[i] = cyc - 1;
        done_q.push_back(i);
        $display("txn m%0d we=%h addr=%h wdata=%h rdata=%h ack=%0d err=%0d cyc=%0d",
                 i, mst_we[i], mst_addr[i], mst_wdata[i], mon_rdata[i], mon_ack[i], mon_err[i], cyc - 1);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    advance_phase();
  endtask

  task automatic issue(input int i, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    mst_we[i] = we; mst_addr[i] = addr; mst_wdata[i] = wdata;
    mst_stb[i] = 1; req_pend[i] = 1; start_cyc[i] = cyc;
  endtask

  task automatic run(input int max_ticks);
    int n;
    n = 0;
    while ((req_pend[0] || req_pend[1]) && n < max_ticks) begin
      tick();
      n++;
    end
    checks++;
    if (req_pend[0] || req_pend[1]) begin
      errors++;
      $display("FAIL completion_timeout: still pending after %0d cycles, expected done", max_ticks);
      mst_stb[0] = 0; mst_stb[1] = 0; req_pend[0] = 0; req_pend[1] = 0;
    end
  endtask

  initial begin
    int got_ack [2];
    for (int i = 0; i < 2; i++) begin
      mst_stb[i] = 0; mst_we[i] = '0; mst_addr[i] = '0; mst_wdata[i] = '0; req_pend[i] = 0;
    end
    mdl_busy = 0; mdl_owner = 0; mdl_last = 1; mdl_age = 0; mdl_read = 0; mdl_exp_rdata = '0;
    sstb_cyc = 0;

    // reset: requests must not leak onto the slave bus
    repeat (2) tick();
    mst_stb[0] = 1; mst_stb[1] = 1;
    #1 check("reset_s_stb", 32'(s_bus.stb), 32'h0);
    tick();
    mst_stb[0] = 0; mst_stb[1] = 0;
    rstn = 1;
    tick();

    for (int w = 0; w < 64; w++) begin
      pl_en = 1; pl_addr = 12'(w);
      pl_data = (w == 4) ? 32'hDEADBEEF : (w == 8) ? 32'hAABBCCDD : $urandom;
      tick();
    end
    pl_en = 0;
    tick();

    // 1: m0 read, ack one cycle after stb
    issue(0, 4'h0, 32'h10, 32'h0);
    run(40);
    check("t1_rdata", res_rdata[0], 32'hDEADBEEF);
    check("t1_latency", 32'(res_cyc[0] - start_cyc[0]), 32'd1);
    check("t1_ack", 32'(res_ack[0]), 32'd1);

    // 2: m1 partial write then readback
    issue(1, 4'b0011, 32'h20, 32'h12345678);
    run(40);
    issue(1, 4'h0, 32'h20, 32'h0);
    run(40);
    check("t2_rdata", res_rdata[1], 32'hAABB5678);

    // 3: both held for 8 transactions -> strict alternation
    done_q.delete();
    begin
      int left [2];
      left[0] = 4; left[1] = 4;
      for (int i = 0; i < 2; i++) begin
        issue(i, 4'h0, 32'(32'h100 + 4 * i), 32'h0);
        left[i]--;
      end
      for (int n = 0; n < 60 && done_q.size() < 8; n++) begin
        tick();
        for (int i = 0; i < 2; i++)
          if (!req_pend[i] && left[i] > 0) begin
            issue(i, 4'h0, 32'(32'h100 + 4 * i), 32'h0);
            left[i]--;
          end
      end
    end
    check("t3_count", 32'(done_q.size()), 32'd8);
    got_ack[0] = 0; got_ack[1] = 0;
    for (int k = 0; k < done_q.size(); k++) begin
      check("t3_order", 32'(done_q[k]), 32'(k % 2));
      got_ack[done_q[k]]++;
    end
    check("t3_m0_acks", 32'(got_ack[0]), 32'd4);
    check("t3_m1_acks", 32'(got_ack[1]), 32'd4);
    run(40);

    // 4: silent RAM -> watchdog err 16 cycles after s_stb, then normal service
    ram_mute = 1;
    issue(1, 4'h0, 32'h30, 32'h0);
    run(40);
    check("t4_err", 32'(res_err[1]), 32'd1);
    check("t4_ack", 32'(res_ack[1]), 32'd0);
    check("t4_delay", 32'(res_cyc[1] - sstb_cyc), 32'd16);
    ram_mute = 0;
    tick();
    issue(0, 4'h0, 32'h10, 32'h0);
    run(40);
    check("t4_recover", res_rdata[0], 32'hDEADBEEF);

    // ack and err together both reach the owner
    ram_both = 1;
    issue(0, 4'h0, 32'h10, 32'h0);
    run(40);
    ram_both = 0;
    check("both_ack", 32'(res_ack[0]), 32'd1);
    check("both_err", 32'(res_err[0]), 32'd1);

    // 5: async reset right after s_stb drops the transaction
    done_q.delete();
    issue(0, 4'h0, 32'h10, 32'h0);
    tick();
    rstn = 0;
    issue(1, 4'h0, 32'h24, 32'h0);
    @(negedge clk);
    model_step();
    #2 rstn = 1;
    #1;
    check("t5_m0_ack", 32'(m0_bus.ack), 32'd0);
    check("t5_m1_ack", 32'(m1_bus.ack), 32'd0);
    check("t5_m0_err", 32'(m0_bus.err), 32'd0);
    check("t5_m1_err", 32'(m1_bus.err), 32'd0);
    check("t5_grant_addr", s_bus.addr, 32'h10);
    model_step();
    advance_phase();
    run(40);
    check("t5_first", (done_q.size() > 0) ? 32'(done_q[0]) : 32'hFFFF_FFFF, 32'd0);
    check("t5_rdata", res_rdata[0], 32'hDEADBEEF);

    // 6: random traffic against the model
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < 2; i++)
        if (!req_pend[i] && $urandom_range(0, 2) != 0)
          issue(i, ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                32'(4 * $urandom_range(0, 63)), $urandom);
      tick();
    end
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
